// File: rtl/MD_pkg.sv
// Shared MD kernel sizing constants and the dump sequencer state type.
package MD_pkg;

    localparam int NUM_PARTICLES     = 256;
    localparam int NUM_INIT_STEPS    = 4;
    localparam int PARTICLE_ID_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } dump_state_t;

endpackage

// File: rtl/dump_pos.sv
// Position-dump read sequencer: sweeps one bank's particle addresses, one read per cycle,
// whenever the MD controller enters (or changes bank within) its dump state.
module dump_pos
    import MD_pkg::*;
#(
    parameter int DUMP_DEPTH = NUM_PARTICLES,
    parameter int NUM_BANKS  = NUM_INIT_STEPS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dump_start,
    input  logic [NUM_BANKS-1:0]         dump_step,
    output logic [NUM_BANKS-1:0]         dump_rd_en,
    output logic [PARTICLE_ID_WIDTH-1:0] dump_rd_addr
);

    localparam logic [PARTICLE_ID_WIDTH-1:0] LAST_ADDR = PARTICLE_ID_WIDTH'(DUMP_DEPTH - 1);

    dump_state_t                  state_q, state_d;
    logic [PARTICLE_ID_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_BANKS-1:0]         rd_en_q, rd_en_d;
    logic [NUM_BANKS-1:0]         step_lat_q, step_lat_d;
    logic [NUM_BANKS-1:0]         step_prev_q, step_prev_d;
    logic                         start_prev_q;
    logic                         trigger;

    // Out-of-range bank indices yield an all-zero enable, so the sweep runs silently.
    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [NUM_BANKS-1:0] step);
        bank_onehot = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (step == NUM_BANKS'(b)) begin
                bank_onehot[b] = 1'b1;
            end
        end
    endfunction

    assign trigger = dump_start && (!start_prev_q || (dump_step != step_prev_q));

    always_comb begin
        state_d     = state_q;
        addr_d      = '0;
        rd_en_d     = '0;
        step_lat_d  = step_lat_q;
        // Bank history is frozen while sweeping so a bank change made mid-sweep
        // is still seen as a change once the current sweep completes.
        step_prev_d = (state_q == SWEEP) ? step_prev_q : dump_step;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d    = SWEEP;
                    step_lat_d = dump_step;
                    rd_en_d    = bank_onehot(dump_step);
                end
            end
            SWEEP: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + PARTICLE_ID_WIDTH'(1);
                    rd_en_d = bank_onehot(step_lat_q);
                end
            end
            DONE: begin
                if (!dump_start) begin
                    state_d = IDLE;
                end else if (trigger) begin
                    state_d    = SWEEP;
                    step_lat_d = dump_step;
                    rd_en_d    = bank_onehot(dump_step);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rd_en_q      <= '0;
            step_lat_q   <= '0;
            step_prev_q  <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rd_en_q      <= rd_en_d;
            step_lat_q   <= step_lat_d;
            step_prev_q  <= step_prev_d;
            start_prev_q <= dump_start;
        end
    end

    assign dump_rd_en   = rd_en_q;
    assign dump_rd_addr = addr_q;

endmodule

// File: tb/tb_dump_pos.sv
// Self-checking bench for dump_pos: queue-based sweep model plus directed and random stimulus.
module tb_dump_pos;
    import MD_pkg::*;

    localparam int DEPTH = 8;
    localparam int BANKS = 4;
    localparam int AW    = PARTICLE_ID_WIDTH;

    typedef struct {
        logic [BANKS-1:0] en;
        logic [AW-1:0]    addr;
    } beat_t;

    logic             clk;
    logic             rst;
    logic             dump_start;
    logic [BANKS-1:0] dump_step;
    logic [BANKS-1:0] dump_rd_en;
    logic [AW-1:0]    dump_rd_addr;

    int total = 0;
    int bad   = 0;

    beat_t            pending[$];
    logic             prevStart = 1'b0;
    logic [BANKS-1:0] stepRef   = '0;
    logic [BANKS-1:0] expEn     = '0;
    logic [AW-1:0]    expAddr   = '0;

    dump_pos #(
        .DUMP_DEPTH(DEPTH),
        .NUM_BANKS (BANKS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dump_start  (dump_start),
        .dump_step   (dump_step),
        .dump_rd_en  (dump_rd_en),
        .dump_rd_addr(dump_rd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BANKS-1:0] bankEn(input logic [BANKS-1:0] step);
        return (int'(step) < BANKS) ? BANKS'(1 << int'(step)) : '0;
    endfunction

    // A sweep occupies DEPTH read beats followed by one idle beat before a new trigger is honoured.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending.delete();
            prevStart = 1'b0;
            stepRef   = '0;
            expEn     = '0;
            expAddr   = '0;
        end else begin
            if (pending.size() == 0) begin
                if (dump_start && (!prevStart || dump_step != stepRef)) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        pending.push_back('{bankEn(dump_step), AW'(i)});
                    end
                    pending.push_back('{'0, '0});
                end
                stepRef = dump_step;
            end
            if (pending.size() > 0) begin
                beat_t b;
                b       = pending.pop_front();
                expEn   = b.en;
                expAddr = b.addr;
            end else begin
                expEn   = '0;
                expAddr = '0;
            end
            prevStart = dump_start;
        end
    end

    task automatic record(input string name, input logic [BANKS-1:0] gotEn, input logic [BANKS-1:0] wantEn,
                          input logic [AW-1:0] gotAddr, input logic [AW-1:0] wantAddr);
        total++;
        if (gotEn !== wantEn || gotAddr !== wantAddr) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got en=%b addr=%0d, want en=%b addr=%0d",
                     name, $time, gotEn, gotAddr, wantEn, wantAddr);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            record("model", dump_rd_en, expEn, dump_rd_addr, expAddr);
        end
    end

    task automatic checkOutput(input string name, input logic [BANKS-1:0] wantEn, input logic [AW-1:0] wantAddr);
        record(name, dump_rd_en, wantEn, dump_rd_addr, wantAddr);
    endtask

    task automatic applyStimulus(input logic start, input logic [BANKS-1:0] step, input int cycles);
        dump_start = start;
        dump_step  = step;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        dump_start = 1'b0;
        dump_step  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset", 4'b0000, 8'd0);
        rst = 1'b0;

        applyStimulus(1'b0, 4'd0, 2);
        checkOutput("idle_after_reset", 4'b0000, 8'd0);
        applyStimulus(1'b1, 4'd0, 1);
        checkOutput("first_read", 4'b0001, 8'd0);
        applyStimulus(1'b1, 4'd0, 3);
        checkOutput("addr3", 4'b0001, 8'd3);
        applyStimulus(1'b1, 4'd0, 4);
        checkOutput("addr7", 4'b0001, 8'd7);
        applyStimulus(1'b1, 4'd0, 1);
        checkOutput("sweep_end", 4'b0000, 8'd0);
        applyStimulus(1'b1, 4'd0, 150);
        checkOutput("held_no_resweep", 4'b0000, 8'd0);

        applyStimulus(1'b1, 4'd1, 1);
        checkOutput("step1_first", 4'b0010, 8'd0);
        applyStimulus(1'b1, 4'd1, 20);

        applyStimulus(1'b1, 4'd0, 3);
        checkOutput("step0_mid", 4'b0001, 8'd2);
        applyStimulus(1'b1, 4'd2, 7);
        checkOutput("queued_step2", 4'b0100, 8'd0);
        applyStimulus(1'b1, 4'd2, 100);
        checkOutput("const_step_idle", 4'b0000, 8'd0);

        applyStimulus(1'b1, 4'd3, 5);
        checkOutput("addr4", 4'b1000, 8'd4);
        rst = 1'b1;
        #1;
        checkOutput("async_clear", 4'b0000, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 4'd3, 1);
        checkOutput("restart_after_reset", 4'b1000, 8'd0);
        applyStimulus(1'b1, 4'd3, 10);

        applyStimulus(1'b1, 4'd5, 3);
        checkOutput("oob_no_enable", 4'b0000, 8'd2);
        applyStimulus(1'b0, 4'd5, 15);
        checkOutput("after_drop", 4'b0000, 8'd0);

        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                applyStimulus($urandom_range(0, 3) != 0, BANKS'($urandom_range(0, 5)), int'($urandom_range(1, 20)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
